// File: rtl/sdram_resp_model.sv
// SDRAM device-side responder: decodes the command bus, tracks bank rows,
// returns read data after CAS latency and latches the first protocol error.
module sdram_resp_model #(
    parameter int AddrWidth = 13,
    parameter int DataWidth = 16,
    parameter int RowBits   = 4,
    parameter int ColBits   = 8,
    parameter int TRcd      = 2,
    parameter int TRp       = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [AddrWidth-1:0] i_dram_addr,
    inout  wire  [DataWidth-1:0] io_dram_data,
    input  logic                 i_dram_ba_0,
    input  logic                 i_dram_ba_1,
    input  logic                 i_dram_ldqm,
    input  logic                 i_dram_udqm,
    input  logic                 i_dram_we_n,
    input  logic                 i_dram_cas_n,
    input  logic                 i_dram_ras_n,
    input  logic                 i_dram_cs_n,
    input  logic                 i_dram_cke,
    output logic                 o_init_done,
    output logic                 o_err,
    output logic [3:0]           o_err_code,
    output logic [15:0]          o_ref_count
);
    localparam int CntW  = 4;
    localparam int HalfW = DataWidth / 2;
    localparam int IdxW  = 2 + RowBits + ColBits;
    localparam int Depth = 1 << IdxW;

    localparam logic [CntW-1:0] RcdLoad = CntW'((TRcd > 0) ? TRcd - 1 : 0);
    localparam logic [CntW-1:0] RpLoad  = CntW'((TRp > 0) ? TRp - 1 : 0);

    localparam logic [3:0] ErrInit    = 4'd1;
    localparam logic [3:0] ErrActOpen = 4'd2;
    localparam logic [3:0] ErrIdle    = 4'd3;
    localparam logic [3:0] ErrBusy    = 4'd4;
    localparam logic [3:0] ErrRcd     = 4'd5;
    localparam logic [3:0] ErrRp      = 4'd6;
    localparam logic [3:0] ErrDq      = 4'd7;
    localparam logic [3:0] ErrMode    = 4'd8;

    typedef enum logic [2:0] {
        WAIT_PALL,
        WAIT_REF1,
        WAIT_REF2,
        WAIT_MRS,
        DONE
    } init_state_t;

    typedef enum logic [2:0] {
        CMD_NOP,
        CMD_ACT,
        CMD_RD,
        CMD_WR,
        CMD_PRE,
        CMD_REF,
        CMD_MRS
    } cmd_t;

    init_state_t state_q, state_d;
    cmd_t        cmd;

    logic [1:0]           bank;
    logic                 a10;
    logic                 init_done;
    logic                 mode_ok;
    logic [3:0]           active_q;
    logic [RowBits-1:0]   row_q [4];
    logic [CntW-1:0]      rcd_q [4];
    logic [CntW-1:0]      rp_q  [4];
    logic [2:0]           cl_q;
    logic [2:0]           dq_vld_q;
    logic [DataWidth-1:0] dq_pipe_q [3];
    logic [1:0]           ld_slot;

    logic [HalfW-1:0]     mem_lo [Depth];
    logic [HalfW-1:0]     mem_hi [Depth];
    logic [IdxW-1:0]      idx;
    logic [DataWidth-1:0] rd_word;
    logic [DataWidth-1:0] dq_in;

    logic                 viol;
    logic [3:0]           viol_code;
    logic                 act_en;
    logic                 acc_en;
    logic                 ref_en;
    logic                 mrs_en;
    logic [3:0]           close_mask;
    logic                 unused_addr;

    assign bank        = {i_dram_ba_1, i_dram_ba_0};
    assign a10         = i_dram_addr[10];
    assign init_done   = (state_q == DONE);
    assign o_init_done = init_done;
    assign unused_addr = ^i_dram_addr;

    assign mode_ok = (i_dram_addr[6:4] == 3'd2 || i_dram_addr[6:4] == 3'd3)
                     && (i_dram_addr[2:0] == 3'd0);

    assign idx     = {bank, row_q[bank], i_dram_addr[ColBits-1:0]};
    assign rd_word = {mem_hi[idx], mem_lo[idx]};
    assign ld_slot = (cl_q == 3'd2) ? 2'd1 : 2'd2;

    // Only stage 0 of the read pipe owns the bus.
    assign io_dram_data = dq_vld_q[0] ? dq_pipe_q[0] : {DataWidth{1'bz}};
    assign dq_in        = io_dram_data;

    always_comb begin
        cmd = CMD_NOP;
        if (i_dram_cke && !i_dram_cs_n) begin
            unique case ({i_dram_ras_n, i_dram_cas_n, i_dram_we_n})
                3'b011:  cmd = CMD_ACT;
                3'b101:  cmd = CMD_RD;
                3'b100:  cmd = CMD_WR;
                3'b010:  cmd = CMD_PRE;
                3'b001:  cmd = CMD_REF;
                3'b000:  cmd = CMD_MRS;
                default: cmd = CMD_NOP;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        viol       = 1'b0;
        viol_code  = 4'd0;
        act_en     = 1'b0;
        acc_en     = 1'b0;
        ref_en     = 1'b0;
        mrs_en     = 1'b0;
        close_mask = 4'b0000;
        unique case (cmd)
            CMD_ACT: begin
                if (!init_done) begin
                    viol      = 1'b1;
                    viol_code = ErrInit;
                end else if (active_q[bank]) begin
                    viol      = 1'b1;
                    viol_code = ErrActOpen;
                end else begin
                    act_en = 1'b1;
                    if (rp_q[bank] != '0) begin
                        viol      = 1'b1;
                        viol_code = ErrRp;
                    end
                end
            end
            CMD_RD, CMD_WR: begin
                if (!init_done) begin
                    viol      = 1'b1;
                    viol_code = ErrInit;
                end else if (!active_q[bank]) begin
                    viol      = 1'b1;
                    viol_code = ErrIdle;
                end else begin
                    acc_en = 1'b1;
                    if (rcd_q[bank] != '0) begin
                        viol      = 1'b1;
                        viol_code = ErrRcd;
                    end else if (cmd == CMD_WR && dq_vld_q[0]) begin
                        viol      = 1'b1;
                        viol_code = ErrDq;
                    end
                    if (a10) close_mask[bank] = 1'b1;
                end
            end
            CMD_PRE: begin
                close_mask = a10 ? 4'b1111 : (4'b0001 << bank);
                if (state_q == WAIT_PALL && a10) state_d = WAIT_REF1;
            end
            CMD_REF: begin
                if (|active_q) begin
                    viol      = 1'b1;
                    viol_code = ErrBusy;
                end else begin
                    ref_en = 1'b1;
                    if (state_q == WAIT_REF1) state_d = WAIT_REF2;
                    else if (state_q == WAIT_REF2) state_d = WAIT_MRS;
                end
            end
            CMD_MRS: begin
                if (|active_q) begin
                    viol      = 1'b1;
                    viol_code = ErrBusy;
                end else if (!mode_ok) begin
                    viol      = 1'b1;
                    viol_code = ErrMode;
                end else begin
                    mrs_en = 1'b1;
                    if (state_q == WAIT_MRS) state_d = DONE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= WAIT_PALL;
        end else if (i_dram_cke) begin
            state_q <= state_d;
        end
    end

    // Timers count down toward zero; zero means the bank timing is met.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            active_q <= 4'b0000;
            for (int b = 0; b < 4; b++) begin
                row_q[b] <= '0;
                rcd_q[b] <= '0;
                rp_q[b]  <= '0;
            end
        end else if (i_dram_cke) begin
            for (int b = 0; b < 4; b++) begin
                if (rcd_q[b] != '0) rcd_q[b] <= rcd_q[b] - 1'b1;
                if (rp_q[b] != '0) rp_q[b] <= rp_q[b] - 1'b1;
                if (close_mask[b]) begin
                    active_q[b] <= 1'b0;
                    rp_q[b]     <= RpLoad;
                end
            end
            if (act_en) begin
                active_q[bank] <= 1'b1;
                row_q[bank]    <= i_dram_addr[RowBits-1:0];
                rcd_q[bank]    <= RcdLoad;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cl_q     <= 3'd3;
            dq_vld_q <= 3'b000;
            for (int s = 0; s < 3; s++) dq_pipe_q[s] <= '0;
        end else if (i_dram_cke) begin
            if (mrs_en) cl_q <= i_dram_addr[6:4];
            dq_vld_q     <= {1'b0, dq_vld_q[2:1]};
            dq_pipe_q[0] <= dq_pipe_q[1];
            dq_pipe_q[1] <= dq_pipe_q[2];
            if (acc_en && cmd == CMD_RD) begin
                dq_vld_q[ld_slot]  <= 1'b1;
                dq_pipe_q[ld_slot] <= rd_word;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (acc_en && cmd == CMD_WR) begin
            if (!i_dram_ldqm) mem_lo[idx] <= dq_in[HalfW-1:0];
            if (!i_dram_udqm) mem_hi[idx] <= dq_in[DataWidth-1:HalfW];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_err       <= 1'b0;
            o_err_code  <= 4'd0;
            o_ref_count <= 16'd0;
        end else begin
            if (viol && !o_err) begin
                o_err      <= 1'b1;
                o_err_code <= viol_code;
            end
            if (ref_en && o_ref_count != 16'hFFFF) begin
                o_ref_count <= o_ref_count + 16'd1;
            end
        end
    end

endmodule
